// File: rtl/uop_bundler.sv
// Micro-op queue that packs cracked 6502 micro-ops into WIDTH-wide, NOP-padded bundles
// for the decoder. Oldest micro-op lands in the highest slot.
module uop_bundler #(
    parameter int unsigned      WIDTH        = 4,
    parameter int unsigned      UOP_W        = 24,
    parameter int unsigned      DEPTH        = 8,
    parameter int unsigned      IDLE_TIMEOUT = 4,
    parameter logic [UOP_W-1:0] NOP_UOP      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UOP_W-1:0]         uop_in,
    input  logic                     uop_in_valid,
    output logic                     uop_in_ready,
    input  logic                     drain,
    input  logic                     flush,
    output logic [WIDTH*UOP_W-1:0]   bundle_out,
    output logic                     bundle_valid,
    input  logic                     bundle_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] WidthC   = CW'(WIDTH);
    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [3:0]    TimeoutC = 4'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWait, StFull} tstate_e;

    logic [UOP_W-1:0]       mem_q [DEPTH];
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx;
    logic [CW-1:0]          count_q, count_d, avail_n, pop_n;
    logic [3:0]             timer_q, timer_d;
    tstate_e                state_q, state_d;
    logic                   valid_q, valid_d;
    logic [WIDTH*UOP_W-1:0] bundle_q, bundle_d, formed;
    logic                   push, form, load;

    assign uop_in_ready = count_q < DepthC;
    assign push         = uop_in_valid & uop_in_ready & ~flush;
    assign avail_n      = (count_q < WidthC) ? count_q : WidthC;
    assign form         = (count_q >= WidthC) |
                          ((drain | (timer_q == TimeoutC)) & (count_q != '0));
    assign load         = ~flush & form & (~valid_q | bundle_ready);
    assign pop_n        = load ? avail_n : '0;

    // Oldest entry goes to slot WIDTH-1; slots beyond the available count are padded.
    always_comb begin
        formed = '0;
        idx    = rd_ptr_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            idx = rd_ptr_q + PW'(i);
            formed[UOP_W*(int'(WIDTH)-1-i) +: UOP_W] =
                (CW'(i) < avail_n) ? mem_q[idx] : NOP_UOP;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - pop_n;
        valid_d  = load ? 1'b1 : (bundle_ready ? 1'b0 : valid_q);
        bundle_d = load ? formed : bundle_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end
    end

    always_comb begin
        state_d = StWait;
        if (count_d == '0) begin
            state_d = StIdle;
        end else if (count_d >= WidthC) begin
            state_d = StFull;
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (flush || load || push || state_q != StWait) begin
            timer_d = '0;
        end else if (timer_q < TimeoutC) begin
            timer_d = timer_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uop_in;
        end
    end

    assign bundle_out   = bundle_q;
    assign bundle_valid = valid_q;
    assign occupancy    = count_q;

endmodule

// File: tb/tb_uop_bundler.sv
// Directed stimulus with a bundle scoreboard; a negedge monitor checks every presented bundle.
module tb_uop_bundler;
    localparam int W = 4;
    localparam int U = 24;

    typedef logic [W*U-1:0] bundle_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [U-1:0] uop_in;
    logic         uop_in_valid, uop_in_ready, drain, flush, bundle_valid, bundle_ready;
    bundle_t      bundle_out;
    logic [3:0]   occupancy;

    bundle_t exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    uop_bundler #(
        .WIDTH(4), .UOP_W(24), .DEPTH(8), .IDLE_TIMEOUT(4), .NOP_UOP(24'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uop_in       (uop_in),
        .uop_in_valid (uop_in_valid),
        .uop_in_ready (uop_in_ready),
        .drain        (drain),
        .flush        (flush),
        .bundle_out   (bundle_out),
        .bundle_valid (bundle_valid),
        .bundle_ready (bundle_ready),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    function automatic bundle_t mk(input logic [U-1:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    function automatic logic [U-1:0] uv(input int base, input int k);
        return U'(base + k);
    endfunction

    task automatic chk(input string name, input bundle_t act, input bundle_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One input cycle; returns 1ns after the edge that consumed it.
    task automatic cyc(input logic v, input logic [U-1:0] u, input logic dr, input logic fl);
        uop_in_valid = v;
        uop_in       = u;
        drain        = dr;
        flush        = fl;
        @(posedge clk);
        #1;
        uop_in_valid = 1'b0;
        drain        = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: every presented bundle must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst && bundle_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bundle: got %h want none", bundle_out);
            end else begin
                chk("bundle", bundle_out, exp_q[0]);
                if (bundle_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; uop_in = '0; uop_in_valid = 1'b0; drain = 1'b0; flush = 1'b0;
        bundle_ready = 1'b1;
        #12;
        chk("rst_valid", bundle_t'(bundle_valid), '0);
        chk("rst_out", bundle_out, '0);
        chk("rst_occ", bundle_t'(occupancy), '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", bundle_t'(uop_in_ready), bundle_t'(1'b1));

        // 1: full bundle, oldest in slot 3
        exp_q.push_back(mk(24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004));
        for (int k = 1; k <= 4; k++) cyc(1'b1, uv(32'hA00000, k), 1'b0, 1'b0);
        chk("t1_not_yet", bundle_t'(bundle_valid), '0);
        idle(1);
        chk("t1_valid", bundle_t'(bundle_valid), bundle_t'(1'b1));
        chk("t1_occ", bundle_t'(occupancy), '0);
        idle(1);
        chk("t1_drop", bundle_t'(bundle_valid), '0);

        // 2: idle timeout pads a partial bundle
        exp_q.push_back(mk(24'hB00001, 24'hB00002, 24'h0, 24'h0));
        cyc(1'b1, 24'hB00001, 1'b0, 1'b0);
        cyc(1'b1, 24'hB00002, 1'b0, 1'b0);
        idle(4);
        chk("t2_wait", bundle_t'(bundle_valid), '0);
        idle(1);
        chk("t2_valid", bundle_t'(bundle_valid), bundle_t'(1'b1));
        idle(1);

        // 3: backpressure fills queue, then bundles stream out
        bundle_ready = 1'b0;
        exp_q.push_back(mk(uv(32'hC00000, 1), uv(32'hC00000, 2), uv(32'hC00000, 3),
                           uv(32'hC00000, 4)));
        exp_q.push_back(mk(uv(32'hC00000, 5), uv(32'hC00000, 6), uv(32'hC00000, 7),
                           uv(32'hC00000, 8)));
        exp_q.push_back(mk(uv(32'hC00000, 9), uv(32'hC00000, 10), uv(32'hC00000, 11),
                           uv(32'hC00000, 12)));
        for (int k = 1; k <= 12; k++) cyc(1'b1, uv(32'hC00000, k), 1'b0, 1'b0);
        chk("t3_occ_full", bundle_t'(occupancy), bundle_t'(4'd8));
        chk("t3_in_ready", bundle_t'(uop_in_ready), '0);
        cyc(1'b1, 24'hC0DEAD, 1'b0, 1'b0);
        chk("t3_drop_push", bundle_t'(occupancy), bundle_t'(4'd8));
        idle(2);
        bundle_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_occ_b2", bundle_t'(occupancy), bundle_t'(4'd4));
        chk("t3_valid_b2", bundle_t'(bundle_valid), bundle_t'(1'b1));
        @(posedge clk); #1;
        chk("t3_occ_b3", bundle_t'(occupancy), '0);
        chk("t3_valid_b3", bundle_t'(bundle_valid), bundle_t'(1'b1));
        idle(1);
        chk("t3_done", bundle_t'(bundle_valid), '0);

        // 4: drain alongside the first push does nothing; next drain emits
        exp_q.push_back(mk(24'hE00001, 24'h0, 24'h0, 24'h0));
        cyc(1'b1, 24'hE00001, 1'b1, 1'b0);
        chk("t4_occ1", bundle_t'(occupancy), bundle_t'(4'd1));
        chk("t4_no_bundle", bundle_t'(bundle_valid), '0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t4_valid", bundle_t'(bundle_valid), bundle_t'(1'b1));
        chk("t4_occ0", bundle_t'(occupancy), '0);
        idle(1);

        // 5: flush discards queue, held bundle and same-cycle push
        bundle_ready = 1'b0;
        exp_q.push_back(mk(uv(32'hF00000, 1), uv(32'hF00000, 2), uv(32'hF00000, 3),
                           uv(32'hF00000, 4)));
        for (int k = 1; k <= 9; k++) cyc(1'b1, uv(32'hF00000, k), 1'b0, 1'b0);
        chk("t5_occ5", bundle_t'(occupancy), bundle_t'(4'd5));
        chk("t5_valid", bundle_t'(bundle_valid), bundle_t'(1'b1));
        cyc(1'b1, 24'hF0DEAD, 1'b1, 1'b1);
        exp_q.delete();
        chk("t5_flush_occ", bundle_t'(occupancy), '0);
        chk("t5_flush_valid", bundle_t'(bundle_valid), '0);
        bundle_ready = 1'b1;
        exp_q.push_back(mk(24'h510001, 24'h510002, 24'h510003, 24'h510004));
        for (int k = 1; k <= 4; k++) cyc(1'b1, uv(32'h510000, k), 1'b0, 1'b0);
        idle(2);

        // 6: async reset mid-stream
        bundle_ready = 1'b0;
        exp_q.push_back(mk(24'h600001, 24'h600002, 24'h600003, 24'h600004));
        for (int k = 1; k <= 7; k++) cyc(1'b1, uv(32'h600000, k), 1'b0, 1'b0);
        chk("t6_occ3", bundle_t'(occupancy), bundle_t'(4'd3));
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_valid", bundle_t'(bundle_valid), '0);
        chk("t6_rst_out", bundle_out, '0);
        chk("t6_rst_occ", bundle_t'(occupancy), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        bundle_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_in_ready", bundle_t'(uop_in_ready), bundle_t'(1'b1));
        exp_q.push_back(mk(24'h700001, 24'h700002, 24'h700003, 24'h700004));
        for (int k = 1; k <= 4; k++) cyc(1'b1, uv(32'h700000, k), 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk("scoreboard_empty", bundle_t'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
